rj_loader: RTL and testbench
============================

# rj_loader

Serial-to-parallel loader that fills the 16-entry rj coefficient memory of the MSDAP. It shifts in sixteen 16-bit rj words from a bit-serial input (MSB first, one word per frame) and issues one write per word into the rj memory. It drives the memory's write port (`write_enable`, `rjwrite`, `in_data`), and reports completion to the main controller so the coefficient load phase can advance.

## Interface
- No parameters; depth (16 words) and word width (16 bits) are fixed.
- `Sclk` input 1: system clock, all logic on rising edge.
- `Reset_n` input 1: asynchronous, active-low reset.
- `start` input 1: one-cycle pulse; begins, or restarts, a 16-word load.
- `frame` input 1: qualifies `bit_valid`; high marks the MSB of a word.
- `bit_valid` input 1: one-cycle strobe, already synchronized to `Sclk`; `bit_in` is sampled when it is high.
- `bit_in` input 1: serial data bit.
- `write_enable` output 1: one-cycle write strobe to the rj memory.
- `rjwrite` output 4: write address, which equals the word index 0..15.
- `in_data` output 16: assembled word; holds its value between writes.
- `busy` output 1: high while a load is in progress.
- `rj_done` output 1: level; high after word 15 is written, until the next `start` or reset.
- `frame_err` output 1: sticky framing error; present only with `RJ_LOADER_FRAME_ERR_EN`.

## Operation
- FSM states: IDLE, WAIT_FRAME, SHIFT, WRITE, DONE.
  - IDLE: `start` clears the word index and bit count, then goes to WAIT_FRAME. `busy` becomes 1.
  - WAIT_FRAME: `bit_valid`=1 with `frame`=0 is dropped. `bit_valid`=1 with `frame`=1 loads `bit_in` as bit 15, sets bit count=1, and goes to SHIFT.
  - SHIFT: each `bit_valid` shifts `bit_in` into the LSB and increments the bit count. `frame` is ignored unless the macro is set.
  - SHIFT, 16th bit: the assembled word is registered into `in_data` and the FSM goes to WRITE.
  - WRITE: lasts exactly one cycle.
    - `write_enable`=1 and `rjwrite`=index.
    - After the cycle, the index increments.
    - If index was 15, go to DONE, where `rj_done`=1 and `busy`=0. Otherwise go to WAIT_FRAME.
  - DONE: holds until `start` or reset.
- `start` in any state other than IDLE:
  - Aborts the current load and clears the index, bit count and `rj_done`.
  - Goes to WAIT_FRAME.
  - If `start` coincides with WRITE, that write still completes and the index is then cleared.
- `bit_valid` arriving in IDLE, WRITE or DONE is dropped. Upstream guarantees at least 2 `Sclk` cycles between `bit_valid` strobes.
- The 4-bit index wraps naturally and is never used beyond 15.

## Timing
- Reset values: `write_enable`=0, `rjwrite`=0, `in_data`=0, `busy`=0, `rj_done`=0, `frame_err`=0; FSM in IDLE.
- Reset asserted mid-load aborts the load immediately, with no write and no partial word retained.
- `busy` rises on the edge that samples `start`.
- Write latency: `write_enable` is high for the single cycle following the edge that sampled the 16th bit.
  - `in_data` and `rjwrite` are valid in that same cycle.
  - The memory captures on the next rising edge.
- `rj_done` rises, and `busy` falls, on the edge that ends the WRITE cycle of word 15.
- A full load needs 256 valid bits plus 16 write cycles. With strobes every k cycles it takes ≈ 256·k + 16 cycles.

## Configuration
- `RJ_LOADER_FRAME_ERR_EN` defined:
  - In SHIFT, a `bit_valid` with `frame`=1 at bit count 1..15 sets sticky `frame_err`=1.
  - That bit is loaded as the MSB of a new word (bit count=1), discarding the partial word. The index is unchanged.
  - `frame_err` clears only on `start` or reset.
- `RJ_LOADER_FRAME_ERR_EN` undefined:
  - There is no `frame_err` port.
  - `frame` in SHIFT is ignored and the bit is shifted normally.

## Test plan
- Reset, then `start`, then 16 words 0x0001, 0x0002 … 0x0010, strobe period 4 → 16 `write_enable` pulses with `rjwrite`=0..15 and `in_data`=0x0001..0x0010. `rj_done`=1 and `busy`=0 one cycle after the last write.
- Word 0xA5C3 sent MSB first → `in_data`=0xA5C3, with `write_enable` high exactly one cycle, the cycle after the 16th strobe.
- 3 strobes with `frame`=0 in WAIT_FRAME, then a framed 0x1234 → the 3 bits are ignored and the write is 0x1234 at `rjwrite`=0.
- Reset_n pulsed low after 5 words, then `start` and 16 words 0xFFFF → all outputs are 0 during reset and the new load writes addresses 0..15, starting at 0.
- `start` during word 7 → load restarts and the next write goes to `rjwrite`=0. `start` in DONE clears `rj_done` on the next edge.
- With the macro: `frame`=1 at bit 8 of word 2, then 0xBEEF → `frame_err`=1 and the write is 0xBEEF at `rjwrite`=2. Without the macro, the same stimulus gives no `frame_err` port and a normal shift.

Source files
------------

// File: rtl/rj_loader_if.sv
// Bus bundle between the serial rj source, the rj_loader and the rj coefficient memory.
// Carries frame_err only when RJ_LOADER_FRAME_ERR_EN is defined.
interface rj_loader_if;
  logic        start;
  logic        frame;
  logic        bit_valid;
  logic        bit_in;
  logic        write_enable;
  logic [3:0]  rjwrite;
  logic [15:0] in_data;
  logic        busy;
  logic        rj_done;
`ifdef RJ_LOADER_FRAME_ERR_EN
  logic        frame_err;
`endif

  modport master (
`ifdef RJ_LOADER_FRAME_ERR_EN
    input  frame_err,
`endif
    output start, frame, bit_valid, bit_in,
    input  write_enable, rjwrite, in_data, busy, rj_done
  );

  modport slave (
`ifdef RJ_LOADER_FRAME_ERR_EN
    output frame_err,
`endif
    input  start, frame, bit_valid, bit_in,
    output write_enable, rjwrite, in_data, busy, rj_done
  );
endinterface

// File: rtl/rj_loader.sv
// Serial-to-parallel loader for the 16-entry MSDAP rj coefficient memory (MSB first, one word per frame).
// Optional sticky framing-error detection is enabled by defining RJ_LOADER_FRAME_ERR_EN.
module rj_loader (
  input  logic       Sclk,
  input  logic       Reset_n,
  rj_loader_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE,
    WAIT_FRAME,
    SHIFT,
    WRITE,
    DONE
  } state_e;

  state_e      state_q;
  logic [3:0]  idx_q;
  logic [3:0]  bitcnt_q;
  logic [14:0] shreg_q;
  logic [15:0] in_data_q;
  logic        we_q;
  logic        busy_q;
  logic        done_q;
`ifdef RJ_LOADER_FRAME_ERR_EN
  logic        ferr_q;
`endif

  // Bits accumulate LSB-justified; after the 16th bit the first (framed) bit sits at bit 15.
  logic [15:0] word_d;
  assign word_d = {shreg_q, bus.bit_in};

  always_ff @(posedge Sclk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q   <= IDLE;
      idx_q     <= '0;
      bitcnt_q  <= '0;
      shreg_q   <= '0;
      in_data_q <= '0;
      we_q      <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
`ifdef RJ_LOADER_FRAME_ERR_EN
      ferr_q    <= 1'b0;
`endif
    end else begin
      we_q <= 1'b0;
      // A start during WRITE still lets that write land: we_q is already high this cycle.
      if (bus.start) begin
        state_q  <= WAIT_FRAME;
        idx_q    <= '0;
        bitcnt_q <= '0;
        shreg_q  <= '0;
        busy_q   <= 1'b1;
        done_q   <= 1'b0;
`ifdef RJ_LOADER_FRAME_ERR_EN
        ferr_q   <= 1'b0;
`endif
      end else begin
        case (state_q)
          IDLE, DONE: ;
          WAIT_FRAME: begin
            if (bus.bit_valid && bus.frame) begin
              shreg_q  <= {14'b0, bus.bit_in};
              bitcnt_q <= 4'd1;
              state_q  <= SHIFT;
            end
          end
          SHIFT: begin
            if (bus.bit_valid) begin
`ifdef RJ_LOADER_FRAME_ERR_EN
              if (bus.frame) begin
                ferr_q   <= 1'b1;
                shreg_q  <= {14'b0, bus.bit_in};
                bitcnt_q <= 4'd1;
              end else
`endif
              if (bitcnt_q == 4'd15) begin
                in_data_q <= word_d;
                we_q      <= 1'b1;
                bitcnt_q  <= '0;
                state_q   <= WRITE;
              end else begin
                shreg_q  <= word_d[14:0];
                bitcnt_q <= bitcnt_q + 4'd1;
              end
            end
          end
          WRITE: begin
            idx_q <= idx_q + 4'd1;
            if (idx_q == 4'd15) begin
              state_q <= DONE;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
            end else begin
              state_q <= WAIT_FRAME;
            end
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign bus.write_enable = we_q;
  assign bus.rjwrite      = idx_q;
  assign bus.in_data      = in_data_q;
  assign bus.busy         = busy_q;
  assign bus.rj_done      = done_q;
`ifdef RJ_LOADER_FRAME_ERR_EN
  assign bus.frame_err    = ferr_q;
`endif

endmodule

// File: tb/tb_rj_loader.sv
// Self-checking bench for rj_loader: random serial words against an expected write list.
`timescale 1ns/1ps
module tb_rj_loader;
  logic Sclk    = 1'b0;
  logic Reset_n = 1'b0;

  rj_loader_if bus();
  rj_loader dut (.Sclk(Sclk), .Reset_n(Reset_n), .bus(bus));

  always #5 Sclk = ~Sclk;

  int pass_cnt  = 0;
  int total_cnt = 0;

  // Reference model: each completed framed word after start goes to address = its position in the load.
  logic [19:0] obs_q[$];
  logic [19:0] exp_q[$];
  int unsigned model_idx = 0;

  always @(negedge Sclk)
    if (bus.write_enable === 1'b1) obs_q.push_back({bus.rjwrite, bus.in_data});

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached, got timeout want completion");
    $fatal(1, "watchdog expired");
  end

  task automatic start_now();
    bus.start = 1'b1;
    @(negedge Sclk);
    bus.start = 1'b0;
    model_idx = 0;
  endtask

  task automatic pulse_start();
    @(negedge Sclk);
    start_now();
  endtask

  task automatic strobe(input logic b, input logic fr);
    @(negedge Sclk);
    bus.bit_valid = 1'b1;
    bus.frame     = fr;
    bus.bit_in    = b;
    @(negedge Sclk);
    bus.bit_valid = 1'b0;
    bus.frame     = 1'b0;
    bus.bit_in    = 1'b0;
  endtask

  task automatic send_word(input logic [15:0] w, input int unsigned k, input bit push);
    for (int i = 15; i >= 0; i--) begin
      repeat (k - 2) @(negedge Sclk);
      strobe(w[i], i == 15);
    end
    if (push) begin
      exp_q.push_back({model_idx[3:0], w});
      model_idx++;
    end
  endtask

  task automatic send_bits(input logic [15:0] w, input int unsigned n, input int unsigned k);
    for (int i = 0; i < int'(n); i++) begin
      repeat (k - 2) @(negedge Sclk);
      strobe(w[15 - i], i == 0);
    end
  endtask

  task automatic test_reset();
    bus.start = 0; bus.frame = 0; bus.bit_valid = 0; bus.bit_in = 0;
    Reset_n = 1'b0;
    repeat (3) @(negedge Sclk);
    total_cnt++; if (bus.write_enable !== 1'b0) $display("FAIL reset_we: got %b want 0", bus.write_enable); else pass_cnt++;
    total_cnt++; if (bus.rjwrite !== 4'd0) $display("FAIL reset_rjwrite: got %h want 0", bus.rjwrite); else pass_cnt++;
    total_cnt++; if (bus.in_data !== 16'd0) $display("FAIL reset_in_data: got %h want 0", bus.in_data); else pass_cnt++;
    total_cnt++; if (bus.busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", bus.busy); else pass_cnt++;
    total_cnt++; if (bus.rj_done !== 1'b0) $display("FAIL reset_rj_done: got %b want 0", bus.rj_done); else pass_cnt++;
`ifdef RJ_LOADER_FRAME_ERR_EN
    total_cnt++; if (bus.frame_err !== 1'b0) $display("FAIL reset_frame_err: got %b want 0", bus.frame_err); else pass_cnt++;
`endif
    Reset_n = 1'b1;
    repeat (2) @(negedge Sclk);
    total_cnt++; if (bus.busy !== 1'b0) $display("FAIL idle_busy: got %b want 0", bus.busy); else pass_cnt++;
  endtask

  task automatic test_sequential_load();
    obs_q.delete(); exp_q.delete();
    pulse_start();
    total_cnt++; if (bus.busy !== 1'b1) $display("FAIL seq_busy_rise: got %b want 1", bus.busy); else pass_cnt++;
    for (int w = 1; w <= 16; w++) send_word(16'(w), 4, 1);
    total_cnt++; if (bus.rj_done !== 1'b0) $display("FAIL seq_done_early: got %b want 0", bus.rj_done); else pass_cnt++;
    @(negedge Sclk);
    total_cnt++; if (bus.rj_done !== 1'b1) $display("FAIL seq_done: got %b want 1", bus.rj_done); else pass_cnt++;
    total_cnt++; if (bus.busy !== 1'b0) $display("FAIL seq_busy_fall: got %b want 0", bus.busy); else pass_cnt++;
    total_cnt++; if (obs_q.size() != exp_q.size()) $display("FAIL seq_count: got %0d want %0d", obs_q.size(), exp_q.size()); else pass_cnt++;
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      total_cnt++;
      if (obs_q[i] !== exp_q[i]) $display("FAIL seq_write[%0d]: got %h want %h", i, obs_q[i], exp_q[i]); else pass_cnt++;
    end
  endtask

  task automatic test_latency();
    int unsigned k;
    logic [15:0] w;
    obs_q.delete(); exp_q.delete();
    k = $urandom_range(2, 6);
    w = 16'hA5C3;
    pulse_start();
    for (int i = 15; i >= 1; i--) begin
      repeat (k - 2) @(negedge Sclk);
      strobe(w[i], i == 15);
    end
    repeat (k - 2) @(negedge Sclk);
    @(negedge Sclk);
    bus.bit_valid = 1'b1; bus.bit_in = w[0];
    total_cnt++; if (bus.write_enable !== 1'b0) $display("FAIL lat_we_before: got %b want 0", bus.write_enable); else pass_cnt++;
    @(negedge Sclk);
    bus.bit_valid = 1'b0; bus.bit_in = 1'b0;
    total_cnt++; if (bus.write_enable !== 1'b1) $display("FAIL lat_we: got %b want 1", bus.write_enable); else pass_cnt++;
    total_cnt++; if (bus.in_data !== 16'hA5C3) $display("FAIL lat_data: got %h want a5c3", bus.in_data); else pass_cnt++;
    total_cnt++; if (bus.rjwrite !== 4'd0) $display("FAIL lat_addr: got %h want 0", bus.rjwrite); else pass_cnt++;
    @(negedge Sclk);
    total_cnt++; if (bus.write_enable !== 1'b0) $display("FAIL lat_we_after: got %b want 0", bus.write_enable); else pass_cnt++;
    total_cnt++; if (bus.in_data !== 16'hA5C3) $display("FAIL lat_data_hold: got %h want a5c3", bus.in_data); else pass_cnt++;
    total_cnt++; if (obs_q.size() != 1) $display("FAIL lat_count: got %0d want 1", obs_q.size()); else pass_cnt++;
  endtask

  task automatic test_random_load();
    obs_q.delete(); exp_q.delete();
    pulse_start();
    for (int n = 0; n < 16; n++) send_word(16'($urandom), $urandom_range(2, 5), 1);
    @(negedge Sclk);
    total_cnt++; if (bus.rj_done !== 1'b1) $display("FAIL rnd_done: got %b want 1", bus.rj_done); else pass_cnt++;
    total_cnt++; if (obs_q.size() != exp_q.size()) $display("FAIL rnd_count: got %0d want %0d", obs_q.size(), exp_q.size()); else pass_cnt++;
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      total_cnt++;
      if (obs_q[i] !== exp_q[i]) $display("FAIL rnd_write[%0d]: got %h want %h", i, obs_q[i], exp_q[i]); else pass_cnt++;
    end
  endtask

  task automatic test_unframed();
    obs_q.delete(); exp_q.delete();
    pulse_start();
    for (int i = 0; i < 3; i++) begin
      repeat (1) @(negedge Sclk);
      strobe(1'($urandom), 1'b0);
    end
    send_word(16'h1234, 3, 1);
    @(negedge Sclk);
    total_cnt++; if (obs_q.size() != 1) $display("FAIL unf_count: got %0d want 1", obs_q.size()); else pass_cnt++;
    if (obs_q.size() > 0) begin
      total_cnt++;
      if (obs_q[0] !== 20'h0_1234) $display("FAIL unf_write: got %h want 01234", obs_q[0]); else pass_cnt++;
    end
  endtask

  task automatic test_reset_midload();
    int snap;
    obs_q.delete(); exp_q.delete();
    pulse_start();
    for (int n = 0; n < 5; n++) send_word(16'($urandom), 2, 1);
    send_bits(16'($urandom), 6, 3);
    snap = obs_q.size();
    @(negedge Sclk);
    Reset_n = 1'b0;
    #1;
    total_cnt++; if (bus.write_enable !== 1'b0) $display("FAIL rst_we: got %b want 0", bus.write_enable); else pass_cnt++;
    total_cnt++; if (bus.rjwrite !== 4'd0) $display("FAIL rst_rjwrite: got %h want 0", bus.rjwrite); else pass_cnt++;
    total_cnt++; if (bus.in_data !== 16'd0) $display("FAIL rst_in_data: got %h want 0", bus.in_data); else pass_cnt++;
    total_cnt++; if (bus.busy !== 1'b0) $display("FAIL rst_busy: got %b want 0", bus.busy); else pass_cnt++;
    total_cnt++; if (bus.rj_done !== 1'b0) $display("FAIL rst_done: got %b want 0", bus.rj_done); else pass_cnt++;
    repeat (2) @(negedge Sclk);
    Reset_n = 1'b1;
    total_cnt++; if (snap != 5 || obs_q.size() != 5) $display("FAIL rst_prewrites: got %0d/%0d want 5/5", snap, obs_q.size()); else pass_cnt++;
    obs_q.delete(); exp_q.delete();
    pulse_start();
    for (int n = 0; n < 16; n++) send_word(16'hFFFF, 2, 1);
    @(negedge Sclk);
    total_cnt++; if (bus.rj_done !== 1'b1) $display("FAIL rst_reload_done: got %b want 1", bus.rj_done); else pass_cnt++;
    total_cnt++; if (obs_q.size() != exp_q.size()) $display("FAIL rst_count: got %0d want %0d", obs_q.size(), exp_q.size()); else pass_cnt++;
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      total_cnt++;
      if (obs_q[i] !== exp_q[i]) $display("FAIL rst_write[%0d]: got %h want %h", i, obs_q[i], exp_q[i]); else pass_cnt++;
    end
  endtask

  task automatic test_restart();
    obs_q.delete(); exp_q.delete();
    pulse_start();
    for (int n = 0; n < 7; n++) send_word(16'($urandom), 2, 1);
    send_bits(16'($urandom), 8, 2);
    pulse_start();
    send_word(16'($urandom), 3, 1);
    send_word(16'($urandom), 3, 1);
    start_now();
    for (int n = 0; n < 16; n++) send_word(16'($urandom), $urandom_range(2, 4), 1);
    @(negedge Sclk);
    total_cnt++; if (bus.rj_done !== 1'b1) $display("FAIL rs_done: got %b want 1", bus.rj_done); else pass_cnt++;
    pulse_start();
    total_cnt++; if (bus.rj_done !== 1'b0) $display("FAIL rs_done_clear: got %b want 0", bus.rj_done); else pass_cnt++;
    total_cnt++; if (bus.busy !== 1'b1) $display("FAIL rs_busy: got %b want 1", bus.busy); else pass_cnt++;
    total_cnt++; if (obs_q.size() != exp_q.size()) $display("FAIL rs_count: got %0d want %0d", obs_q.size(), exp_q.size()); else pass_cnt++;
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      total_cnt++;
      if (obs_q[i] !== exp_q[i]) $display("FAIL rs_write[%0d]: got %h want %h", i, obs_q[i], exp_q[i]); else pass_cnt++;
    end
  endtask

  task automatic test_frame_midword();
    logic [15:0] x;
    obs_q.delete(); exp_q.delete();
    x = 16'($urandom);
    pulse_start();
    send_word(16'($urandom), 3, 1);
    send_word(16'($urandom), 3, 1);
`ifdef RJ_LOADER_FRAME_ERR_EN
    total_cnt++; if (bus.frame_err !== 1'b0) $display("FAIL fe_before: got %b want 0", bus.frame_err); else pass_cnt++;
`endif
    send_bits(x, 8, 3);
    send_word(16'hBEEF, 3, 0);
`ifdef RJ_LOADER_FRAME_ERR_EN
    exp_q.push_back({4'd2, 16'hBEEF});
`else
    exp_q.push_back({4'd2, x[15:8], 8'hBE});
`endif
    model_idx = 3;
    send_word(16'($urandom), 3, 1);
    @(negedge Sclk);
`ifdef RJ_LOADER_FRAME_ERR_EN
    total_cnt++; if (bus.frame_err !== 1'b1) $display("FAIL fe_set: got %b want 1", bus.frame_err); else pass_cnt++;
    pulse_start();
    total_cnt++; if (bus.frame_err !== 1'b0) $display("FAIL fe_clear: got %b want 0", bus.frame_err); else pass_cnt++;
`endif
    total_cnt++; if (obs_q.size() != exp_q.size()) $display("FAIL fe_count: got %0d want %0d", obs_q.size(), exp_q.size()); else pass_cnt++;
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      total_cnt++;
      if (obs_q[i] !== exp_q[i]) $display("FAIL fe_write[%0d]: got %h want %h", i, obs_q[i], exp_q[i]); else pass_cnt++;
    end
  endtask

  initial begin
    test_reset();
    test_sequential_load();
    test_latency();
    test_random_load();
    test_unframed();
    test_reset_midload();
    test_restart();
    test_frame_midword();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
